// File: rtl/video_sig_gen.sv
// rtl/video_sig_gen.sv - raster timing generator with sync/active outputs and pipelined sync copies
module video_sig_gen #(
  parameter int H_ACTIVE    = 1280,
  parameter int H_FP        = 110,
  parameter int H_SYNC      = 40,
  parameter int H_BP        = 220,
  parameter int V_ACTIVE    = 720,
  parameter int V_FP        = 5,
  parameter int V_SYNC      = 5,
  parameter int V_BP        = 20,
  parameter int SYNC_POL    = 1,
  parameter int PIPE_STAGES = 4
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        active_draw_out,
  output logic        new_frame_out,
  output logic [5:0]  frame_count_out,
  output logic        hsync_pipe_out,
  output logic        vsync_pipe_out,
  output logic        active_draw_pipe_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
  localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        SYNC_ACT   = (SYNC_POL != 0);
  localparam logic        SYNC_IDLE  = !SYNC_ACT;

  // Reset asserts asynchronously but releases through two flops; run gates all state.
  logic [1:0] rst_sync;
  logic       run;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign run = rst_sync[1];

  logic        h_wrap;
  logic        v_wrap;
  logic [10:0] h_next;
  logic [9:0]  v_next;
  logic        active_next;
  logic        hsync_next;
  logic        vsync_next;
  logic        new_frame_next;

  // Outputs are registered from the next-count decode so they stay aligned with the counters.
  always_comb begin
    h_wrap = (hcount_out == H_LAST);
    v_wrap = (vcount_out == V_LAST);
    h_next = h_wrap ? 11'd0 : hcount_out + 11'd1;
    v_next = vcount_out;
    if (h_wrap) begin
      v_next = v_wrap ? 10'd0 : vcount_out + 10'd1;
    end
    active_next    = (h_next < H_ACT) && (v_next < V_ACT);
    hsync_next     = ((h_next >= HS_START) && (h_next < HS_END)) ? SYNC_ACT : SYNC_IDLE;
    vsync_next     = ((v_next >= VS_START) && (v_next < VS_END)) ? SYNC_ACT : SYNC_IDLE;
    new_frame_next = (h_next == H_ACT) && (v_next == V_ACT);
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hcount_out      <= H_LAST;
      vcount_out      <= V_LAST;
      hsync_out       <= SYNC_IDLE;
      vsync_out       <= SYNC_IDLE;
      active_draw_out <= 1'b0;
      new_frame_out   <= 1'b0;
      frame_count_out <= 6'd0;
    end else if (run) begin
      hcount_out      <= h_next;
      vcount_out      <= v_next;
      hsync_out       <= hsync_next;
      vsync_out       <= vsync_next;
      active_draw_out <= active_next;
      new_frame_out   <= new_frame_next;
      if (new_frame_next) begin
        frame_count_out <= frame_count_out + 6'd1;
      end
    end
  end

  logic [PIPE_STAGES-1:0] hs_pipe;
  logic [PIPE_STAGES-1:0] vs_pipe;
  logic [PIPE_STAGES-1:0] ad_pipe;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hs_pipe <= {PIPE_STAGES{SYNC_IDLE}};
      vs_pipe <= {PIPE_STAGES{SYNC_IDLE}};
      ad_pipe <= '0;
    end else if (run) begin
      hs_pipe[0] <= hsync_out;
      vs_pipe[0] <= vsync_out;
      ad_pipe[0] <= active_draw_out;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
        ad_pipe[i] <= ad_pipe[i-1];
      end
    end
  end

  assign hsync_pipe_out       = hs_pipe[PIPE_STAGES-1];
  assign vsync_pipe_out       = vs_pipe[PIPE_STAGES-1];
  assign active_draw_pipe_out = ad_pipe[PIPE_STAGES-1];

endmodule
